pll_freq_sequencer: RTL

- Avalon-MM master that programs the reconfigurable PLL peripheral from a single divider request (n, m, c0).
- Converts each divider value into high/low/bypass/odd counter words, issues the 12 parameter writes in a fixed order, then issues the trigger write.
- Runs in the reconfigured clock domain; the host-clock slave side is reached through the fabric clock-crossing bridge.
- Its own reset asserts when the PLL reconfigures, so a successful request always ends in reset.

---
 rtl/pll_freq_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pll_freq_sequencer.sv
// pll_freq_sequencer: Avalon-MM master that turns one (n, m, c0) divider
// request into the 12 PLL counter parameter writes plus the trigger write.
// Optional readback verification is compiled in with PLL_SEQ_READBACK_EN.
module pll_freq_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int DIV_W          = 9
) (
  input  logic             cso_reconfigclk_clock,
  input  logic             reset_synchronizer,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_n,
  input  logic [DIV_W-1:0] req_m,
  input  logic [DIV_W-1:0] req_c0,
  output logic             seq_busy,
  output logic             seq_error,
  output logic [1:0]       seq_err_code,
  output logic [7:0]       avm_address,
  output logic [31:0]      avm_writedata,
  output logic             avm_write,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WRITE, S_TRIGGER, S_WAIT_RESET, S_FAIL
`ifdef PLL_SEQ_READBACK_EN
    , S_READ, S_CMP
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] n_q, n_d, m_q, m_d, c0_q, c0_d;
  logic [3:0]       idx_q, idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
`ifdef PLL_SEQ_READBACK_EN
  logic [DIV_W-1:0] rd_q, rd_d;
  logic             unused_readdata;
  assign unused_readdata = ^avm_readdata[31:DIV_W];
`else
  logic             unused_readdata;
  assign unused_readdata = ^avm_readdata;
`endif

  logic [DIV_W-1:0] cur_v, high_v, field;
  logic [2:0]       pcode;
  logic [7:0]       param_addr;

  // Pick the divider and counter word addressed by the current write index
  always_comb begin
    cur_v = c0_q;
    pcode = 3'd4;
    case (idx_q[3:2])
      2'd0: begin cur_v = n_q; pcode = 3'd0; end
      2'd1: begin cur_v = m_q; pcode = 3'd1; end
      default: ;
    endcase
    // high = ceil(v/2), same as (v+1)>>1 without needing a carry bit
    high_v = {1'b0, cur_v[DIV_W-1:1]} + {{(DIV_W-1){1'b0}}, cur_v[0]};
    case (idx_q[1:0])
      2'd0:    field = high_v;
      2'd1:    field = cur_v - high_v;
      2'd2:    field = {{(DIV_W-1){1'b0}}, (cur_v == DIV_W'(1))};
      default: field = {{(DIV_W-1){1'b0}}, cur_v[0]};
    endcase
    // type codes 0,1,4,5 are the index low bits spread to bits 2 and 0
    param_addr = {1'b0, pcode, 1'b0, idx_q[1], 1'b0, idx_q[0]};
  end

  // Bus outputs decode straight from state so a reset drops them at once
  always_comb begin
    req_ready     = (state_q == S_IDLE);
    seq_busy      = (state_q != S_IDLE);
    seq_error     = err_q;
    seq_err_code  = code_q;
    avm_write     = (state_q == S_WRITE) || (state_q == S_TRIGGER);
    avm_address   = 8'h00;
    avm_writedata = 32'h0;
`ifdef PLL_SEQ_READBACK_EN
    avm_read      = (state_q == S_READ);
    if (state_q == S_READ) avm_address = param_addr;
`else
    avm_read      = 1'b0;
`endif
    if (state_q == S_WRITE) begin
      avm_address   = param_addr;
      avm_writedata = {{(32-DIV_W){1'b0}}, field};
    end else if (state_q == S_TRIGGER) begin
      avm_address   = 8'h80;
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    c0_d    = c0_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    err_d   = err_q;
    code_d  = code_q;
`ifdef PLL_SEQ_READBACK_EN
    rd_d    = rd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          n_d     = req_n;
          m_d     = req_m;
          c0_d    = req_c0;
          err_d   = 1'b0;
          code_d  = 2'd0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((n_q == '0) || (m_q == '0) || (c0_q == '0)) begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          state_d = S_FAIL;
        end else begin
          idx_d   = 4'd0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!avm_waitrequest) begin
          if (idx_q == 4'd11) begin
            idx_d   = 4'd0;
`ifdef PLL_SEQ_READBACK_EN
            state_d = S_READ;
`else
            state_d = S_TRIGGER;
`endif
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef PLL_SEQ_READBACK_EN
      S_READ: begin
        if (!avm_waitrequest) begin
          rd_d    = avm_readdata[DIV_W-1:0];
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        if (rd_q != field) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = S_FAIL;
        end else if (idx_q == 4'd11) begin
          state_d = S_TRIGGER;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_READ;
        end
      end
`endif
      S_TRIGGER: begin
        if (!avm_waitrequest) begin
          timer_d = TW'(TIMEOUT_CYCLES);
          state_d = S_WAIT_RESET;
        end
      end
      S_WAIT_RESET: begin
        // The PLL reset normally ends this state; expiry means it never came
        if (timer_q <= TW'(1)) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = S_FAIL;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_FAIL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously by the PLL-driven reset
  always_ff @(posedge cso_reconfigclk_clock or posedge reset_synchronizer) begin
    if (reset_synchronizer) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      c0_q    <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
`ifdef PLL_SEQ_READBACK_EN
      rd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      c0_q    <= c0_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      code_q  <= code_d;
`ifdef PLL_SEQ_READBACK_EN
      rd_q    <= rd_d;
`endif
    end
  end

endmodule
